// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: register file, op decode, operand forwarding and an
// output register toward the ALU, with valid/ready flow control.
module id_ex_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [15:0]       in_imm,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_fwd_en,
  input  logic [REG_AW-1:0] ex_fwd_addr,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic              ex_is_load,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [3:0]        out_control,
  output logic [DATA_W-1:0] out_oper1,
  output logic [DATA_W-1:0] out_oper2,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_reg_wr,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic [DATA_W-1:0] out_store_data,
  output logic              illegal_op
);

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_MUL  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd5;
  localparam logic [5:0] OP_LDB  = 6'd10;
  localparam logic [5:0] OP_LDW  = 6'd11;
  localparam logic [5:0] OP_STB  = 6'd12;
  localparam logic [5:0] OP_STW  = 6'd13;
  localparam logic [5:0] OP_MOV  = 6'd14;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              dec_legal;
  logic [3:0]        dec_ctl;
  logic              dec_use_rt;
  logic              dec_imm;
  logic              dec_zero_op2;
  logic              dec_dest_rt;
  logic              dec_rw;
  logic              dec_mr;
  logic              dec_mw;

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] simm;
  logic [DATA_W-1:0] oper2_nxt;
  logic [DATA_W-1:0] store_nxt;
  logic [REG_AW-1:0] dest_nxt;

  logic              hazard;
  logic              adv;
  logic              accept;

  always_comb begin
    dec_legal    = 1'b1;
    dec_ctl      = 4'd0;
    dec_use_rt   = 1'b0;
    dec_imm      = 1'b0;
    dec_zero_op2 = 1'b0;
    dec_dest_rt  = 1'b0;
    dec_rw       = 1'b0;
    dec_mr       = 1'b0;
    dec_mw       = 1'b0;
    case (in_op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR: begin
        dec_ctl    = in_op[3:0];
        dec_use_rt = 1'b1;
        dec_rw     = 1'b1;
      end
      OP_ADDI: begin
        dec_ctl     = 4'd0;
        dec_imm     = 1'b1;
        dec_dest_rt = 1'b1;
        dec_rw      = 1'b1;
      end
      OP_LDB, OP_LDW: begin
        dec_ctl     = in_op[3:0];
        dec_imm     = 1'b1;
        dec_dest_rt = 1'b1;
        dec_rw      = 1'b1;
        dec_mr      = 1'b1;
      end
      OP_STB, OP_STW: begin
        dec_ctl    = in_op[3:0];
        dec_imm    = 1'b1;
        dec_use_rt = 1'b1;
        dec_mw     = 1'b1;
      end
      OP_MOV: begin
        dec_ctl      = 4'd14;
        dec_zero_op2 = 1'b1;
        dec_rw       = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Source priority: EX result, then same-cycle WB write, then the array.
  always_comb begin
    if (in_rs == '0)
      rs_val = '0;
    else if (ex_fwd_en && !ex_is_load && (in_rs == ex_fwd_addr))
      rs_val = ex_fwd_data;
    else if (wb_en && (in_rs == wb_addr))
      rs_val = wb_data;
    else
      rs_val = regs[in_rs];
  end

  always_comb begin
    if (in_rt == '0)
      rt_val = '0;
    else if (ex_fwd_en && !ex_is_load && (in_rt == ex_fwd_addr))
      rt_val = ex_fwd_data;
    else if (wb_en && (in_rt == wb_addr))
      rt_val = wb_data;
    else
      rt_val = regs[in_rt];
  end

  always_comb begin
    simm = {{(DATA_W-16){in_imm[15]}}, in_imm};
    if (dec_imm)
      oper2_nxt = simm;
    else if (dec_zero_op2)
      oper2_nxt = '0;
    else
      oper2_nxt = rt_val;
    store_nxt = dec_mw ? rt_val : '0;
    dest_nxt  = dec_dest_rt ? in_rt : in_rd;
  end

  // Only sources the op really reads can stall; unknown ops read nothing.
  assign hazard = ex_fwd_en && ex_is_load && (ex_fwd_addr != '0) && dec_legal &&
                  ((ex_fwd_addr == in_rs) || (dec_use_rt && (ex_fwd_addr == in_rt)));

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_control    <= '0;
      out_oper1      <= '0;
      out_oper2      <= '0;
      out_dest       <= '0;
      out_reg_wr     <= 1'b0;
      out_mem_rd     <= 1'b0;
      out_mem_wr     <= 1'b0;
      out_store_data <= '0;
      illegal_op     <= 1'b0;
    end else begin
      illegal_op <= accept && !dec_legal;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (adv) begin
        out_valid <= accept && dec_legal;
        if (accept && dec_legal) begin
          out_control    <= dec_ctl;
          out_oper1      <= rs_val;
          out_oper2      <= oper2_nxt;
          out_dest       <= dest_nxt;
          out_reg_wr     <= dec_rw;
          out_mem_rd     <= dec_mr;
          out_mem_wr     <= dec_mw;
          out_store_data <= store_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: decode table through a scoreboard,
// plus forwarding, load-use stall, backpressure, flush, illegal op and reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_fwd_en;
  logic [4:0]  ex_fwd_addr;
  logic [31:0] ex_fwd_data;
  logic        ex_is_load;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_control;
  logic [31:0] out_oper1, out_oper2;
  logic [4:0]  out_dest;
  logic        out_reg_wr, out_mem_rd, out_mem_wr;
  logic [31:0] out_store_data;
  logic        illegal_op;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
    .ex_is_load(ex_is_load), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_control(out_control), .out_oper1(out_oper1),
    .out_oper2(out_oper2), .out_dest(out_dest), .out_reg_wr(out_reg_wr),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_store_data(out_store_data), .illegal_op(illegal_op)
  );

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [3:0]  ctl;
    logic [31:0] o1, o2;
    logic [4:0]  dest;
    logic        rw, mr, mw;
    logic [31:0] sd;
    logic        vld;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[14];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [15:0] imm, input logic [3:0] ctl,
                              input logic [31:0] o1, input logic [31:0] o2, input logic [4:0] dest,
                              input logic rw, input logic mr, input logic mw,
                              input logic [31:0] sd, input logic vld);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.imm = imm; v.ctl = ctl;
    v.o1 = o1; v.o2 = o2; v.dest = dest; v.rw = rw; v.mr = mr; v.mw = mw;
    v.sd = sd; v.vld = vld;
    return v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Called at the falling edge: an output with valid&&ready transfers next edge.
  task automatic mon_check();
    vec_t e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got valid control=%0d oper1=0x%08h, expected no output",
                 out_control, out_oper1);
      end else begin
        e = exp_q.pop_front();
        chk32("control", 32'(out_control), 32'(e.ctl));
        chk32("oper1", out_oper1, e.o1);
        chk32("oper2", out_oper2, e.o2);
        chk32("dest", 32'(out_dest), 32'(e.dest));
        chk1("reg_wr", out_reg_wr, e.rw);
        chk1("mem_rd", out_mem_rd, e.mr);
        chk1("mem_wr", out_mem_wr, e.mw);
        if (e.mw) chk32("store_data", out_store_data, e.sd);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_check();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input vec_t v);
    in_op = v.op; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd; in_imm = v.imm;
  endtask

  task automatic issue(input vec_t v, input bit rnd);
    bit acc = 1'b0;
    set_fields(v);
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      mon_check();
      if (in_ready) begin
        acc = 1'b1;
        if (v.vld) exp_q.push_back(v);
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue_timeout: got in_ready=0 for 40 cycles, expected accept (op %0d)", v.op);
    end
    in_valid = 1'b0;
  endtask

  task automatic probe_ready(input string name, input logic exp);
    @(negedge clk);
    mon_check();
    chk1(name, in_ready, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (3) tick();
    chk32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish by 100us, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_fwd_en = 1'b0; ex_fwd_addr = '0;
    ex_fwd_data = '0; ex_is_load = 1'b0; flush = 1'b0; out_ready = 1'b1;

    tbl[0]  = mk(6'd0,  5'd1, 5'd2,  5'd3,  16'h0000, 4'd0,  32'd5,          32'd7,          5'd3,  1'b1, 1'b0, 1'b0, 32'd0,          1'b1);
    tbl[1]  = mk(6'd1,  5'd2, 5'd1,  5'd6,  16'h0000, 4'd1,  32'd7,          32'd5,          5'd6,  1'b1, 1'b0, 1'b0, 32'd0,          1'b1);
    tbl[2]  = mk(6'd2,  5'd1, 5'd1,  5'd7,  16'h0000, 4'd2,  32'd5,          32'd5,          5'd7,  1'b1, 1'b0, 1'b0, 32'd0,          1'b1);
    tbl[3]  = mk(6'd3,  5'd5, 5'd2,  5'd8,  16'h0000, 4'd3,  32'h8000_0000,  32'd7,          5'd8,  1'b1, 1'b0, 1'b0, 32'd0,          1'b1);
    tbl[4]  = mk(6'd4,  5'd0, 5'd2,  5'd9,  16'h0000, 4'd4,  32'd0,          32'd7,          5'd9,  1'b1, 1'b0, 1'b0, 32'd0,          1'b1);
    tbl[5]  = mk(6'd5,  5'd1, 5'd4,  5'd20, 16'hFFFE, 4'd0,  32'd5,          32'hFFFF_FFFE,  5'd4,  1'b1, 1'b0, 1'b0, 32'd0,          1'b1);
    tbl[6]  = mk(6'd5,  5'd2, 5'd21, 5'd3,  16'h7FFF, 4'd0,  32'd7,          32'h0000_7FFF,  5'd21, 1'b1, 1'b0, 1'b0, 32'd0,          1'b1);
    tbl[7]  = mk(6'd11, 5'd2, 5'd10, 5'd1,  16'h0004, 4'd11, 32'd7,          32'd4,          5'd10, 1'b1, 1'b1, 1'b0, 32'd0,          1'b1);
    tbl[8]  = mk(6'd10, 5'd5, 5'd12, 5'd1,  16'h8000, 4'd10, 32'h8000_0000,  32'hFFFF_8000,  5'd12, 1'b1, 1'b1, 1'b0, 32'd0,          1'b1);
    tbl[9]  = mk(6'd13, 5'd1, 5'd2,  5'd11, 16'h0008, 4'd13, 32'd5,          32'd8,          5'd11, 1'b0, 1'b0, 1'b1, 32'd7,          1'b1);
    tbl[10] = mk(6'd12, 5'd2, 5'd5,  5'd0,  16'hFFFF, 4'd12, 32'd7,          32'hFFFF_FFFF,  5'd0,  1'b0, 1'b0, 1'b1, 32'h8000_0000,  1'b1);
    tbl[11] = mk(6'd14, 5'd0, 5'd2,  5'd13, 16'h1234, 4'd14, 32'd0,          32'd0,          5'd13, 1'b1, 1'b0, 1'b0, 32'd0,          1'b1);
    tbl[12] = mk(6'd14, 5'd5, 5'd1,  5'd14, 16'h0000, 4'd14, 32'h8000_0000,  32'd0,          5'd14, 1'b1, 1'b0, 1'b0, 32'd0,          1'b1);
    tbl[13] = mk(6'd63, 5'd1, 5'd2,  5'd3,  16'h0000, 4'd0,  32'd0,          32'd0,          5'd0,  1'b0, 1'b0, 1'b0, 32'd0,          1'b0);

    // Reset values
    #12;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk32("rst_out_control", 32'(out_control), 32'd0);
    chk32("rst_out_oper1", out_oper1, 32'd0);
    chk32("rst_out_oper2", out_oper2, 32'd0);
    chk32("rst_out_dest", 32'(out_dest), 32'd0);
    chk1("rst_illegal_op", illegal_op, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);

    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    wb_write(5'd5, 32'h8000_0000);

    // Decode table, back-to-back then with random output backpressure
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 14; i++) issue(tbl[i], p == 1);
      drain();
    end

    // EX forward beats a same-cycle WB write
    ex_fwd_en = 1'b1; ex_fwd_addr = 5'd1; ex_fwd_data = 32'h100; ex_is_load = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
    issue(mk(6'd0, 5'd1, 5'd2, 5'd3, 16'h0, 4'd0, 32'h100, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1), 1'b0);
    ex_fwd_en = 1'b0;
    wb_data = 32'h77;
    issue(mk(6'd0, 5'd1, 5'd1, 5'd3, 16'h0, 4'd0, 32'h77, 32'h77, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1), 1'b0);
    wb_en = 1'b0;
    issue(mk(6'd1, 5'd1, 5'd2, 5'd4, 16'h0, 4'd1, 32'h77, 32'd7, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1), 1'b0);
    ex_fwd_en = 1'b1; ex_fwd_addr = 5'd0; ex_fwd_data = 32'hBEEF;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
    issue(mk(6'd4, 5'd0, 5'd0, 5'd1, 16'h0, 4'd4, 32'd0, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1), 1'b0);
    ex_fwd_addr = 5'd2; ex_fwd_data = 32'h222;
    wb_addr = 5'd2; wb_data = 32'h333;
    issue(mk(6'd3, 5'd0, 5'd2, 5'd6, 16'h0, 4'd3, 32'd0, 32'h222, 5'd6, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1), 1'b0);
    ex_fwd_en = 1'b0; wb_en = 1'b0;
    drain();

    // Load-use stall on rt, released by dropping the load with a WB of r2
    ex_fwd_en = 1'b1; ex_is_load = 1'b1; ex_fwd_addr = 5'd2; ex_fwd_data = 32'hBAD;
    set_fields(mk(6'd1, 5'd1, 5'd2, 5'd5, 16'h0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
    in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      mon_check();
      chk1("stall_in_ready", in_ready, 1'b0);
      chk1("stall_out_valid", out_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    ex_is_load = 1'b0; ex_fwd_en = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd9;
    issue(mk(6'd1, 5'd1, 5'd2, 5'd5, 16'h0, 4'd1, 32'h77, 32'd9, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1), 1'b0);
    wb_en = 1'b0;
    drain();

    // Which sources a pending load may stall
    ex_fwd_en = 1'b1; ex_is_load = 1'b1; ex_fwd_addr = 5'd2;
    set_fields(mk(6'd5, 5'd1, 5'd2, 5'd0, 16'h1, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
    probe_ready("addi_rt_no_stall", 1'b1);
    set_fields(mk(6'd14, 5'd2, 5'd0, 5'd3, 16'h0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
    probe_ready("mov_rs_stall", 1'b0);
    set_fields(mk(6'd13, 5'd1, 5'd2, 5'd0, 16'h0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
    probe_ready("store_rt_stall", 1'b0);
    ex_fwd_addr = 5'd0;
    set_fields(mk(6'd0, 5'd0, 5'd0, 5'd3, 16'h0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
    probe_ready("load_r0_no_stall", 1'b1);
    ex_fwd_en = 1'b0; ex_is_load = 1'b0;

    // Backpressure hold, then flush kills the held output
    out_ready = 1'b0;
    issue(mk(6'd0, 5'd1, 5'd2, 5'd3, 16'h0, 4'd0, 32'h77, 32'd9, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1), 1'b0);
    set_fields(mk(6'd1, 5'd2, 5'd1, 5'd4, 16'h0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mon_check();
      chk1("hold_in_ready", in_ready, 1'b0);
      chk1("hold_out_valid", out_valid, 1'b1);
      chk32("hold_oper1", out_oper1, 32'h77);
      chk32("hold_dest", 32'(out_dest), 32'd3);
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk1("flush_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    chk1("flush_out_valid", out_valid, 1'b0);
    mon_check();
    @(posedge clk);
    #1;
    issue(mk(6'd1, 5'd2, 5'd1, 5'd4, 16'h0, 4'd1, 32'd9, 32'h77, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1), 1'b0);
    drain();

    // Illegal op: accepted, bubble, one-cycle pulse
    issue(mk(6'd7, 5'd1, 5'd2, 5'd3, 16'h0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0), 1'b0);
    @(negedge clk);
    chk1("illegal_pulse", illegal_op, 1'b1);
    chk1("illegal_bubble", out_valid, 1'b0);
    mon_check();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk1("illegal_pulse_end", illegal_op, 1'b0);
    @(posedge clk);
    #1;

    // Asynchronous reset with a held output
    out_ready = 1'b0;
    issue(mk(6'd14, 5'd1, 5'd0, 5'd9, 16'h0, 4'd14, 32'h77, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_out_valid", out_valid, 1'b0);
    chk32("arst_out_control", 32'(out_control), 32'd0);
    chk32("arst_out_oper1", out_oper1, 32'd0);
    chk32("arst_out_dest", 32'(out_dest), 32'd0);
    chk1("arst_out_reg_wr", out_reg_wr, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(mk(6'd14, 5'd1, 5'd0, 5'd9, 16'h0, 4'd14, 32'd0, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1), 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
